// File: rtl/svx32_rvfi_monitor.sv
// svx32_rvfi_monitor: RVFI retirement monitor; counts retires/traps and checks order, PC chain, x0, post-halt, watchdog.
// Latency: every status register updates on the edge after the retiring/offending cycle; pol_any_err follows the flag register.
// Backpressure: none; pure observer that never stalls the core. Sticky flags hold until pil_clr_err or pil_rst.
module svx32_rvfi_monitor #(
  parameter int NRET        = 1,
  parameter int XLEN        = 32,
  parameter int ILEN        = 32,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                 pil_clk,
  input  logic                 pil_rst,
  input  logic [NRET-1:0]      piv_rvfi_valid,
  input  logic [64*NRET-1:0]   piv_rvfi_order,
  input  logic [ILEN*NRET-1:0] piv_rvfi_insn,
  input  logic [XLEN*NRET-1:0] piv_rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0] piv_rvfi_pc_wdata,
  input  logic [NRET-1:0]      piv_rvfi_trap,
  input  logic [NRET-1:0]      piv_rvfi_halt,
  input  logic [5*NRET-1:0]    piv_rvfi_rd_addr,
  input  logic [XLEN*NRET-1:0] piv_rvfi_rd_wdata,
  input  logic                 pil_clr_err,
  output logic [CNT_W-1:0]     pov_retire_cnt,
  output logic [CNT_W-1:0]     pov_trap_cnt,
  output logic [4:0]           pov_err_flags,
  output logic [2:0]           pov_err_code,
  output logic [63:0]          pov_err_order,
  output logic                 pol_any_err,
  output logic                 pol_halted
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES);

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ORDER = 3'd1;
  localparam logic [2:0] ERR_PC    = 3'd2;
  localparam logic [2:0] ERR_X0    = 3'd3;
  localparam logic [2:0] ERR_WDOG  = 3'd4;
  localparam logic [2:0] ERR_POST  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Registered state
  state_t            r_state;
  logic [WDOG_W-1:0] r_wdog_cnt;
  logic [63:0]       r_exp_order;
  logic              r_last_pc_valid;
  logic [XLEN-1:0]   r_last_pc;
  logic              r_last_trap;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic [CNT_W-1:0]  r_trap_cnt;
  logic [4:0]        r_err_flags;
  logic [2:0]        r_err_code;
  logic [63:0]       r_err_order;

  // Per-cycle evaluation
  logic [NRET:0]     w_vld_below;
  logic              w_any_vld;
  logic [2:0]        w_nvalid;
  logic [2:0]        w_ntrap;
  logic              w_halt_seen;
  logic              w_prev_vld;
  logic [XLEN-1:0]   w_prev_pc;
  logic              w_prev_trap;
  logic [63:0]       w_ch_order;
  logic [XLEN-1:0]   w_ch_pcr;
  logic [XLEN-1:0]   w_ch_pcw;
  logic [4:0]        w_ch_rd;
  logic [XLEN-1:0]   w_ch_wd;
  logic              w_e_order;
  logic              w_e_pc;
  logic              w_e_x0;
  logic              w_e_post;
  logic              w_wdog_hit;
  logic [4:0]        w_new_flags;
  logic              w_cap_vld;
  logic [2:0]        w_cap_code;
  logic [63:0]       w_cap_order;
  logic [CNT_W+2:0]  w_ret_sum;
  logic [CNT_W+2:0]  w_trap_sum;
  logic              w_unused;

  // The instruction word is carried on the bus but not checked here.
  assign w_unused = ^piv_rvfi_insn;

  // Bit k is the valid of channel k-1; channel 0 is always "preceded" so it never sees a gap.
  assign w_vld_below = {piv_rvfi_valid, 1'b1};
  assign w_any_vld   = |piv_rvfi_valid;

  // Walk the channels in retirement order, chaining PC/halt through earlier channels of the same cycle.
  always_comb begin
    w_nvalid    = '0;
    w_ntrap     = '0;
    w_halt_seen = 1'b0;
    w_prev_vld  = r_last_pc_valid;
    w_prev_pc   = r_last_pc;
    w_prev_trap = r_last_trap;
    w_ch_order  = '0;
    w_ch_pcr    = '0;
    w_ch_pcw    = '0;
    w_ch_rd     = '0;
    w_ch_wd     = '0;
    w_e_order   = 1'b0;
    w_e_pc      = 1'b0;
    w_e_x0      = 1'b0;
    w_e_post    = 1'b0;
    w_wdog_hit  = 1'b0;
    w_new_flags = '0;
    w_cap_vld   = 1'b0;
    w_cap_code  = ERR_NONE;
    w_cap_order = '0;
    for (int k = 0; k < NRET; k++) begin
      w_ch_order = piv_rvfi_order[64*k +: 64];
      w_ch_pcr   = piv_rvfi_pc_rdata[XLEN*k +: XLEN];
      w_ch_pcw   = piv_rvfi_pc_wdata[XLEN*k +: XLEN];
      w_ch_rd    = piv_rvfi_rd_addr[5*k +: 5];
      w_ch_wd    = piv_rvfi_rd_wdata[XLEN*k +: XLEN];
      w_e_order  = 1'b0;
      w_e_pc     = 1'b0;
      w_e_x0     = 1'b0;
      w_e_post   = 1'b0;
      if (piv_rvfi_valid[k]) begin
        // w_nvalid is the index of this channel among the valid ones so far.
        w_e_order = !w_vld_below[k] || (w_ch_order != r_exp_order + {61'd0, w_nvalid});
        // A trapped predecessor legitimately redirects the PC, so continuity is not checked.
        w_e_pc    = w_prev_vld && !w_prev_trap && (w_ch_pcr != w_prev_pc);
        w_e_x0    = (w_ch_rd == 5'd0) && (w_ch_wd != '0);
        w_e_post  = (r_state == ST_HALTED) || w_halt_seen;
        w_new_flags[0] = w_new_flags[0] | w_e_order;
        w_new_flags[1] = w_new_flags[1] | w_e_pc;
        w_new_flags[2] = w_new_flags[2] | w_e_x0;
        w_new_flags[4] = w_new_flags[4] | w_e_post;
        if (!w_cap_vld && (w_e_order || w_e_pc || w_e_x0 || w_e_post)) begin
          w_cap_vld   = 1'b1;
          w_cap_order = w_ch_order;
          if (w_e_order)   w_cap_code = ERR_ORDER;
          else if (w_e_pc) w_cap_code = ERR_PC;
          else if (w_e_x0) w_cap_code = ERR_X0;
          else             w_cap_code = ERR_POST;
        end
        w_prev_vld  = 1'b1;
        w_prev_pc   = w_ch_pcw;
        w_prev_trap = piv_rvfi_trap[k];
        if (piv_rvfi_halt[k]) w_halt_seen = 1'b1;
        w_nvalid = w_nvalid + 3'd1;
        if (piv_rvfi_trap[k]) w_ntrap = w_ntrap + 3'd1;
      end
    end
    // Watchdog only fires on a quiet RUN cycle, and loses capture priority to any channel error.
    w_wdog_hit     = (r_state == ST_RUN) && !w_any_vld &&
                     (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
    w_new_flags[3] = w_wdog_hit;
    if (w_wdog_hit && !w_cap_vld) begin
      w_cap_vld   = 1'b1;
      w_cap_code  = ERR_WDOG;
      w_cap_order = '0;
    end
  end

  assign w_ret_sum  = {3'b000, r_retire_cnt} + {{CNT_W{1'b0}}, w_nvalid};
  assign w_trap_sum = {3'b000, r_trap_cnt}   + {{CNT_W{1'b0}}, w_ntrap};

  // Lifecycle FSM plus the idle-cycle watchdog counter that only runs in RUN.
  always_ff @(posedge pil_clk) begin
    if (pil_rst) begin
      r_state    <= ST_IDLE;
      r_wdog_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_halt_seen)    r_state <= ST_HALTED;
          else if (w_any_vld) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_halt_seen) r_state <= ST_HALTED;
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_IDLE;
      endcase
      if (pil_clr_err || (r_state != ST_RUN) || w_any_vld || w_wdog_hit) begin
        r_wdog_cnt <= '0;
      end else begin
        r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
      end
    end
  end

  // Expected order and last-retirement PC/trap carried into the next cycle.
  always_ff @(posedge pil_clk) begin
    if (pil_rst) begin
      r_exp_order     <= '0;
      r_last_pc_valid <= 1'b0;
      r_last_pc       <= '0;
      r_last_trap     <= 1'b0;
    end else begin
      r_exp_order     <= r_exp_order + {61'd0, w_nvalid};
      r_last_pc_valid <= w_prev_vld;
      r_last_pc       <= w_prev_pc;
      r_last_trap     <= w_prev_trap;
    end
  end

  // Saturating retire and trap counters; any carry out of the counter width pins them at all-ones.
  always_ff @(posedge pil_clk) begin
    if (pil_rst) begin
      r_retire_cnt <= '0;
      r_trap_cnt   <= '0;
    end else begin
      if (w_ret_sum[CNT_W+2:CNT_W] != 3'd0) r_retire_cnt <= '1;
      else                                   r_retire_cnt <= w_ret_sum[CNT_W-1:0];
      if (w_trap_sum[CNT_W+2:CNT_W] != 3'd0) r_trap_cnt <= '1;
      else                                    r_trap_cnt <= w_trap_sum[CNT_W-1:0];
    end
  end

  // Sticky flags and first-error capture; a new error in a clear cycle is kept (set beats clear).
  always_ff @(posedge pil_clk) begin
    if (pil_rst) begin
      r_err_flags <= '0;
      r_err_code  <= ERR_NONE;
      r_err_order <= '0;
    end else begin
      r_err_flags <= (pil_clr_err ? 5'd0 : r_err_flags) | w_new_flags;
      if (w_cap_vld && (pil_clr_err || (r_err_code == ERR_NONE))) begin
        r_err_code  <= w_cap_code;
        r_err_order <= w_cap_order;
      end else if (pil_clr_err) begin
        r_err_code  <= ERR_NONE;
        r_err_order <= '0;
      end
    end
  end

  assign pov_retire_cnt = r_retire_cnt;
  assign pov_trap_cnt   = r_trap_cnt;
  assign pov_err_flags  = r_err_flags;
  assign pov_err_code   = r_err_code;
  assign pov_err_order  = r_err_order;
  assign pol_any_err    = |r_err_flags;
  assign pol_halted     = (r_state == ST_HALTED);

endmodule

// File: tb/tb_svx32_rvfi_monitor.sv
// tb_svx32_rvfi_monitor: table vectors, directed watchdog/halt/saturation/reset sequences, then random traffic vs a model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the monitor is a passive observer.
module tb_svx32_rvfi_monitor;

  localparam int WDOG = 8;
  localparam int CMAX = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr_err;
  logic [1:0]   valid;
  logic [127:0] order;
  logic [63:0]  insn;
  logic [63:0]  pc_r;
  logic [63:0]  pc_w;
  logic [1:0]   trap;
  logic [1:0]   halt;
  logic [9:0]   rd_addr;
  logic [63:0]  rd_wdata;
  logic [3:0]   retire_cnt;
  logic [3:0]   trap_cnt;
  logic [4:0]   err_flags;
  logic [2:0]   err_code;
  logic [63:0]  err_order;
  logic         any_err;
  logic         halted;

  int n_tests = 0;
  int n_fail  = 0;

  svx32_rvfi_monitor #(
    .NRET(2), .XLEN(32), .ILEN(32), .CNT_W(4), .WDOG_CYCLES(WDOG)
  ) dut (
    .pil_clk(clk), .pil_rst(rst),
    .piv_rvfi_valid(valid), .piv_rvfi_order(order), .piv_rvfi_insn(insn),
    .piv_rvfi_pc_rdata(pc_r), .piv_rvfi_pc_wdata(pc_w),
    .piv_rvfi_trap(trap), .piv_rvfi_halt(halt),
    .piv_rvfi_rd_addr(rd_addr), .piv_rvfi_rd_wdata(rd_wdata),
    .pil_clr_err(clr_err),
    .pov_retire_cnt(retire_cnt), .pov_trap_cnt(trap_cnt),
    .pov_err_flags(err_flags), .pov_err_code(err_code), .pov_err_order(err_order),
    .pol_any_err(any_err), .pol_halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_ret, input int e_trap, input logic [4:0] e_flags,
                           input int e_code, input logic [63:0] e_ord, input logic e_halted);
    check({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(e_ret));
    check({tag, ".trap_cnt"},   64'(trap_cnt),   64'(e_trap));
    check({tag, ".err_flags"},  64'(err_flags),  64'(e_flags));
    check({tag, ".err_code"},   64'(err_code),   64'(e_code));
    check({tag, ".err_order"},  err_order,       e_ord);
    check({tag, ".any_err"},    64'(any_err),    64'(|e_flags));
    check({tag, ".halted"},     64'(halted),     64'(e_halted));
  endtask

  task automatic idle_inputs();
    valid = '0; order = '0; insn = '0; pc_r = '0; pc_w = '0;
    trap = '0; halt = '0; rd_addr = {5'd1, 5'd1}; rd_wdata = '0;
  endtask

  task automatic set_ch(input int k, input logic v, input logic [63:0] o, input logic [31:0] pcr,
                        input logic [31:0] pcw, input logic tr, input logic h,
                        input logic [4:0] rd, input logic [31:0] wd);
    valid[k]            = v;
    order[64*k +: 64]   = o;
    pc_r[32*k +: 32]    = pcr;
    pc_w[32*k +: 32]    = pcw;
    trap[k]             = tr;
    halt[k]             = h;
    rd_addr[5*k +: 5]   = rd;
    rd_wdata[32*k +: 32] = wd;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        rst, clr;
    logic [1:0]  vld, trp, hlt;
    logic [63:0] o0, o1;
    logic [31:0] pcr0, pcw0, pcr1, pcw1;
    logic [4:0]  rd0;
    logic [31:0] wd0;
    int          e_ret, e_trap;
    logic [4:0]  e_flags;
    int          e_code;
    logic [63:0] e_ord;
    logic        e_halted;
  } vec_t;

  function automatic vec_t row(input logic r, input logic c, input logic [1:0] v, input logic [1:0] tr,
                               input logic [1:0] h, input logic [63:0] o0, input logic [63:0] o1,
                               input logic [31:0] pcr0, input logic [31:0] pcw0,
                               input logic [31:0] pcr1, input logic [31:0] pcw1,
                               input logic [4:0] rd0, input logic [31:0] wd0,
                               input int er, input int et, input logic [4:0] ef, input int ec,
                               input logic [63:0] eo, input logic eh);
    vec_t x;
    x.rst = r; x.clr = c; x.vld = v; x.trp = tr; x.hlt = h; x.o0 = o0; x.o1 = o1;
    x.pcr0 = pcr0; x.pcw0 = pcw0; x.pcr1 = pcr1; x.pcw1 = pcw1; x.rd0 = rd0; x.wd0 = wd0;
    x.e_ret = er; x.e_trap = et; x.e_flags = ef; x.e_code = ec; x.e_ord = eo; x.e_halted = eh;
    return x;
  endfunction

  vec_t tbl[22];

  // ---------------- reference model ----------------
  logic [63:0] m_exp;
  bit          m_have_prev, m_prev_trap, m_started, m_halted;
  logic [31:0] m_prev_pc;
  int          m_idle, m_ret, m_trap, m_code;
  logic [4:0]  m_flags;
  logic [63:0] m_eord;

  task automatic model_step();
    logic [4:0]  nf;
    bit          got, hseen, e_o, e_p, e_x, e_h, hit, run;
    int          code, cnt, ntr;
    logic [63:0] eo, o;
    if (rst) begin
      m_exp = 0; m_have_prev = 0; m_prev_trap = 0; m_prev_pc = 0; m_started = 0; m_halted = 0;
      m_idle = 0; m_ret = 0; m_trap = 0; m_code = 0; m_flags = 0; m_eord = 0;
      return;
    end
    nf = 0; got = 0; hseen = 0; code = 0; cnt = 0; ntr = 0; eo = 0;
    for (int k = 0; k < 2; k++) begin
      if (valid[k]) begin
        o   = order[64*k +: 64];
        e_o = (k == 1 && !valid[0]) || (o != m_exp + 64'(cnt));
        e_p = m_have_prev && !m_prev_trap && (pc_r[32*k +: 32] != m_prev_pc);
        e_x = (rd_addr[5*k +: 5] == 5'd0) && (rd_wdata[32*k +: 32] != 0);
        e_h = m_halted || hseen;
        nf  = nf | {e_h, 1'b0, e_x, e_p, e_o};
        if (!got && (e_o || e_p || e_x || e_h)) begin
          got  = 1;
          eo   = o;
          code = e_o ? 1 : e_p ? 2 : e_x ? 3 : 5;
        end
        m_have_prev = 1;
        m_prev_pc   = pc_w[32*k +: 32];
        m_prev_trap = trap[k];
        if (halt[k]) hseen = 1;
        cnt++;
        if (trap[k]) ntr++;
      end
    end
    run = m_started && !m_halted;
    hit = run && (valid == 0) && (m_idle == WDOG - 1);
    if (hit) nf[3] = 1'b1;
    if (hit && !got) begin got = 1; code = 4; eo = 0; end
    m_flags = (clr_err ? 5'd0 : m_flags) | nf;
    if (got && (m_code == 0 || clr_err)) begin m_code = code; m_eord = eo; end
    else if (clr_err) begin m_code = 0; m_eord = 0; end
    if (clr_err || !run || valid != 0 || hit) m_idle = 0;
    else m_idle++;
    if (valid != 0) m_started = 1;
    if (hseen) m_halted = 1;
    m_exp  = m_exp + 64'(cnt);
    m_ret  = (m_ret + cnt > CMAX) ? CMAX : m_ret + cnt;
    m_trap = (m_trap + ntr > CMAX) ? CMAX : m_trap + ntr;
  endtask

  int          idle_left;
  logic [31:0] chain, pr, pw;
  logic [63:0] o;
  int          m;

  initial begin
    rst = 1'b1; clr_err = 1'b0;
    idle_inputs();

    tbl[0]  = row(1,0,2'b00,2'b00,2'b00, 0,0, 0,0,0,0, 1,0, 0,0,5'h00,0,0,0);
    tbl[1]  = row(0,0,2'b01,2'b00,2'b00, 0,0, 'h0,'h4,0,0, 1,0, 1,0,5'h00,0,0,0);
    tbl[2]  = row(0,0,2'b01,2'b00,2'b00, 1,0, 'h4,'h8,0,0, 1,0, 2,0,5'h00,0,0,0);
    tbl[3]  = row(0,0,2'b01,2'b00,2'b00, 2,0, 'h8,'hC,0,0, 1,0, 3,0,5'h00,0,0,0);
    tbl[4]  = row(1,0,2'b00,2'b00,2'b00, 0,0, 0,0,0,0, 1,0, 0,0,5'h00,0,0,0);
    tbl[5]  = row(0,0,2'b01,2'b00,2'b00, 0,0, 'h0,'h4,0,0, 1,0, 1,0,5'h00,0,0,0);
    tbl[6]  = row(0,0,2'b01,2'b00,2'b00, 1,0, 'h4,'h8,0,0, 1,0, 2,0,5'h00,0,0,0);
    tbl[7]  = row(0,0,2'b01,2'b00,2'b00, 3,0, 'h8,'hC,0,0, 1,0, 3,0,5'h01,1,3,0);
    tbl[8]  = row(0,0,2'b01,2'b00,2'b00, 4,0, 'hC,'h10,0,0, 1,0, 4,0,5'h01,1,3,0);
    tbl[9]  = row(1,0,2'b00,2'b00,2'b00, 0,0, 0,0,0,0, 1,0, 0,0,5'h00,0,0,0);
    tbl[10] = row(0,0,2'b11,2'b00,2'b00, 0,1, 'h0,'h100,'h104,'h108, 1,0, 2,0,5'h02,2,1,0);
    tbl[11] = row(1,0,2'b00,2'b00,2'b00, 0,0, 0,0,0,0, 1,0, 0,0,5'h00,0,0,0);
    tbl[12] = row(0,0,2'b11,2'b01,2'b00, 0,1, 'h0,'h100,'h104,'h108, 1,0, 2,1,5'h00,0,0,0);
    tbl[13] = row(0,0,2'b01,2'b00,2'b00, 2,0, 'h108,'h10C,0,0, 0,5, 3,1,5'h04,3,2,0);
    tbl[14] = row(0,1,2'b00,2'b00,2'b00, 0,0, 0,0,0,0, 1,0, 3,1,5'h00,0,0,0);
    tbl[15] = row(0,1,2'b01,2'b00,2'b00, 9,0, 'h10C,'h110,0,0, 1,0, 4,1,5'h01,1,9,0);
    tbl[16] = row(0,0,2'b01,2'b00,2'b00, 4,0, 'h999,'h99C,0,0, 1,0, 5,1,5'h03,1,9,0);
    tbl[17] = row(1,0,2'b00,2'b00,2'b00, 0,0, 0,0,0,0, 1,0, 0,0,5'h00,0,0,0);
    tbl[18] = row(0,0,2'b10,2'b00,2'b00, 0,0, 0,0,'h0,'h4, 1,0, 1,0,5'h01,1,0,0);
    tbl[19] = row(1,0,2'b00,2'b00,2'b00, 0,0, 0,0,0,0, 1,0, 0,0,5'h00,0,0,0);
    tbl[20] = row(0,0,2'b01,2'b00,2'b00, 5,0, 'h0,'h4,0,0, 0,7, 1,0,5'h05,1,5,0);
    tbl[21] = row(0,0,2'b11,2'b00,2'b01, 1,2, 'h4,'h8,'h8,'hC, 1,0, 3,0,5'h15,1,5,1);

    tick();
    for (int i = 0; i < 22; i++) begin
      idle_inputs();
      rst = tbl[i].rst; clr_err = tbl[i].clr;
      set_ch(0, tbl[i].vld[0], tbl[i].o0, tbl[i].pcr0, tbl[i].pcw0, tbl[i].trp[0], tbl[i].hlt[0],
             tbl[i].rd0, tbl[i].wd0);
      set_ch(1, tbl[i].vld[1], tbl[i].o1, tbl[i].pcr1, tbl[i].pcw1, tbl[i].trp[1], tbl[i].hlt[1],
             5'd1, 32'd0);
      tick();
      check_all($sformatf("tbl%0d", i), tbl[i].e_ret, tbl[i].e_trap, tbl[i].e_flags,
                tbl[i].e_code, tbl[i].e_ord, tbl[i].e_halted);
    end

    // ---- watchdog then halt / post-halt ----
    idle_inputs(); clr_err = 0; rst = 1; tick();
    rst = 0;
    set_ch(0, 1, 0, 'h0, 'h4, 0, 0, 1, 0); tick();
    check_all("wd.retire", 1, 0, 5'h00, 0, 0, 0);
    idle_inputs();
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("wd.idle%0d.flags", i), 64'(err_flags), 64'h0);
    end
    tick();
    check_all("wd.fire", 1, 0, 5'h08, 4, 0, 0);
    set_ch(0, 1, 1, 'h4, 'h8, 0, 1, 1, 0); tick();
    check_all("wd.halt", 2, 0, 5'h08, 4, 0, 1);
    set_ch(0, 1, 2, 'h8, 'hC, 0, 0, 1, 0); tick();
    check_all("wd.posthalt", 3, 0, 5'h18, 4, 0, 1);
    idle_inputs(); clr_err = 1; tick(); clr_err = 0;
    check_all("wd.clr", 3, 0, 5'h00, 0, 0, 1);
    for (int i = 0; i < 12; i++) tick();
    check_all("wd.halted_quiet", 3, 0, 5'h00, 0, 0, 1);

    // ---- saturation and mid-run reset ----
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      set_ch(0, 1, 64'(i), 32'(4*i), 32'(4*i+4), 0, 0, 1, 0);
      tick();
      check($sformatf("sat%0d.retire_cnt", i), 64'(retire_cnt), 64'((i + 1 > CMAX) ? CMAX : i + 1));
    end
    idle_inputs();
    set_ch(0, 1, 16, 'h40, 'h44, 0, 0, 1, 0);
    set_ch(1, 1, 17, 'h44, 'h48, 0, 0, 1, 0);
    tick();
    check_all("sat.hold", 15, 0, 5'h00, 0, 0, 0);
    set_ch(0, 1, 99, 'h1000, 'h1004, 1, 0, 0, 3);
    rst = 1; tick(); rst = 0;
    check_all("rst.mid", 0, 0, 5'h00, 0, 0, 0);
    idle_inputs();
    for (int i = 0; i < 10; i++) tick();
    check_all("rst.idle_no_wdog", 0, 0, 5'h00, 0, 0, 0);
    set_ch(0, 1, 0, 'h500, 'h504, 0, 0, 1, 0); tick();
    check_all("rst.first", 1, 0, 5'h00, 0, 0, 0);

    // ---- random traffic against the model ----
    idle_left = 0;
    idle_inputs(); rst = 1; clr_err = 0;
    model_step(); tick();
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      rst     = ($urandom_range(0, 39) == 0);
      clr_err = ($urandom_range(0, 19) == 0);
      insn    = {$urandom, $urandom};
      if (idle_left > 0) begin
        idle_left--;
      end else if ($urandom_range(0, 15) == 0) begin
        idle_left = $urandom_range(5, 10);
      end else begin
        valid = 2'($urandom_range(0, 3));
      end
      chain = m_prev_pc;
      m = 0;
      for (int k = 0; k < 2; k++) begin
        if (valid[k]) begin
          o = m_exp + 64'(m);
          if ($urandom_range(0, 7) == 0) o = o + 64'($urandom_range(1, 3));
          pr = ($urandom_range(0, 7) == 0) ? $urandom : chain;
          pw = ($urandom_range(0, 3) == 0) ? $urandom : pr + 4;
          chain = pw;
          m++;
        end else begin
          o = {$urandom, $urandom}; pr = $urandom; pw = $urandom;
        end
        set_ch(k, valid[k], o, pr, pw, ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
               5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom);
      end
      model_step();
      tick();
      check_all($sformatf("rnd%0d", c), m_ret, m_trap, m_flags, m_code, m_eord, m_halted);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
